dot_sched: RTL and testbench
============================

# dot_sched

Round-robin scheduler that shares one 4x4-bit multiply-accumulate datapath between two requesters, each needing a 10-element dot product. It grants one requester at a time, steps an element index so the requester drives the matching operand pair, accumulates one product per cycle, and returns the sum tagged with the requester id. It sits between the requesting blocks and the dot-product arithmetic, replacing per-requester 10-multiplier arrays with one sequenced MAC.

## Interface
- N, 10: elements per dot product (N >= 2)
- W, 4: operand width, unsigned
- ACC_W, 32: accumulator/result width (must hold N*(2^W-1)^2)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- req  in  2  per-requester job request; held high until y_valid with matching y_id
- x0, h0  in  W each  requester 0 operand pair for element elem_idx
- x1, h1  in  W each  requester 1 operand pair for element elem_idx
- grant  out  2  one-hot owner of the MAC; 2'b00 when idle
- elem_idx  out  $clog2(N)  element currently consumed
- busy  out  1  high in ACCUM and DONE
- y  out  ACC_W  last completed dot product
- y_valid  out  1  one-cycle completion pulse
- y_id  out  1  requester that owns y

## Operation
- FSM states: IDLE, ACCUM, DONE.
- IDLE: if req != 0, select winner with round-robin (priority to requester not served last); next state ACCUM, grant <= onehot(winner), elem_idx <= 0, acc <= 0. Else stay.
- ACCUM: operands taken from granted requester's x/h at current elem_idx; acc <= acc + x*h; elem_idx increments. When elem_idx == N-1: y <= acc + x*h, y_id <= winner, last_served <= winner, next state DONE.
- DONE: y_valid = 1, grant = 0, elem_idx = 0; next state IDLE unconditionally. req sampled in DONE is ignored.
- Arithmetic: product 2W bits unsigned, zero-extended to ACC_W; no overflow possible within parameter constraint.
- Requester deasserting req mid-job: ignored; job runs to completion and reports.
- Single requester active: served back-to-back regardless of last_served.
- y holds its value until the next completion; y_id likewise.

## Timing
- All outputs registered. Reset values: grant 0, elem_idx 0, busy 0, y 0, y_valid 0, y_id 0, state IDLE, last_served 1 (requester 0 wins first tie).
- Request seen high at edge T in IDLE -> grant and busy high from T+1; elem_idx = k during cycle T+1+k, k = 0..N-1.
- Operands must be valid combinationally within the cycle elem_idx presents them.
- y/y_valid/y_id visible at cycle T+N+1 (DONE); y_valid low at T+N+2.
- Job occupancy N+2 cycles including IDLE arbitration cycle; two contending jobs complete N+2 cycles apart.
- Reset in any state, including mid-ACCUM: next cycle all outputs at reset values; aborted job produces no y_valid; last_served returns to 1.

## Structure
- Package dot_pkg: state enum (IDLE, ACCUM, DONE), default N, W, ACC_W constants, IDX_W = $clog2(N).
- Sub-module rr_arb2: 2-way round-robin arbiter (inputs req, last_served; output one-hot winner); combinational, instantiated once.
- Top holds FSM, index counter, accumulator, result registers.

## Test plan
- After reset, req=2'b01, x0=h0=1 for all elements -> grant=01 for 10 cycles, y=10, y_id=0, y_valid one cycle at T+11.
- req=2'b10, x1=h1=15 all elements -> y=2250, y_id=1.
- req=2'b01, x0=elem_idx, h0=2 -> y=90; confirm elem_idx sequence 0..9.
- req=2'b11 from reset, x0=h0=1, x1=h1=2 -> first y=10 id 0, then y=40 id 1 exactly 12 cycles later; then re-raise both -> requester 0 served next (alternation).
- Reset asserted during ACCUM at elem_idx=5 -> next cycle grant=0, busy=0, y=0; no y_valid; fresh req after reset completes normally.
- req0 dropped at elem_idx=3 -> job still completes with y_valid and y_id=0.

Source files
------------

// File: rtl/dot_pkg.sv
// Shared types and default sizing for the time-multiplexed dot-product scheduler.
package dot_pkg;

    localparam int unsigned N_DEF     = 10;
    localparam int unsigned W_DEF     = 4;
    localparam int unsigned ACC_W_DEF = 32;
    localparam int unsigned IDX_W     = $clog2(N_DEF);

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDone
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on contention the requester not served last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_served,
    output logic [1:0] winner
);

    always_comb begin
        winner = req;
        if (req == 2'b11) begin
            winner = last_served ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/dot_sched.sv
// Shares one unsigned MAC between two requesters, producing one N-element dot product per job.
module dot_sched
    import dot_pkg::*;
#(
    parameter int unsigned N     = N_DEF,
    parameter int unsigned W     = W_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           req,
    input  logic [W-1:0]         x0,
    input  logic [W-1:0]         h0,
    input  logic [W-1:0]         x1,
    input  logic [W-1:0]         h1,
    output logic [1:0]           grant,
    output logic [$clog2(N)-1:0] elem_idx,
    output logic                 busy,
    output logic [ACC_W-1:0]     y,
    output logic                 y_valid,
    output logic                 y_id
);

    localparam int unsigned IW = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    state_e           state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] y_q, y_d;
    logic             y_id_q, y_id_d;
    logic             y_valid_q, y_valid_d;
    logic             busy_q, busy_d;
    logic             last_q, last_d;

    logic [1:0]       win;
    logic [W-1:0]     op_x, op_h;
    logic [2*W-1:0]   prod;
    logic [ACC_W-1:0] acc_sum;

    rr_arb2 u_arb (
        .req         (req),
        .last_served (last_q),
        .winner      (win)
    );

    // grant_q is one-hot while accumulating, so bit 1 doubles as the owner id.
    assign op_x    = grant_q[1] ? x1 : x0;
    assign op_h    = grant_q[1] ? h1 : h0;
    assign prod    = op_x * op_h;
    assign acc_sum = acc_q + ACC_W'(prod);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        y_d       = y_q;
        y_id_d    = y_id_q;
        y_valid_d = 1'b0;
        busy_d    = busy_q;
        last_d    = last_q;
        case (state_q)
            StIdle: begin
                if (|req) begin
                    state_d = StAccum;
                    grant_d = win;
                    idx_d   = '0;
                    acc_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            StAccum: begin
                acc_d = acc_sum;
                if (idx_q == LAST_IDX) begin
                    y_d       = acc_sum;
                    y_id_d    = grant_q[1];
                    last_d    = grant_q[1];
                    y_valid_d = 1'b1;
                    grant_d   = 2'b00;
                    idx_d     = '0;
                    state_d   = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                // Requests seen here are deliberately ignored; arbitration resumes in idle.
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            grant_q   <= 2'b00;
            idx_q     <= '0;
            acc_q     <= '0;
            y_q       <= '0;
            y_id_q    <= 1'b0;
            y_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            last_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            y_q       <= y_d;
            y_id_q    <= y_id_d;
            y_valid_q <= y_valid_d;
            busy_q    <= busy_d;
            last_q    <= last_d;
        end
    end

    assign grant    = grant_q;
    assign elem_idx = idx_q;
    assign busy     = busy_q;
    assign y        = y_q;
    assign y_valid  = y_valid_q;
    assign y_id     = y_id_q;

endmodule

// File: tb/tb_dot_sched.sv
// Directed and randomized bench for dot_sched against a job-level reference model.
module tb_dot_sched;

    localparam int N     = 10;
    localparam int W     = 4;
    localparam int ACC_W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       req;
    logic [W-1:0]     x0, h0, x1, h1;
    logic [1:0]       grant;
    logic [3:0]       elem_idx;
    logic             busy;
    logic [ACC_W-1:0] y;
    logic             y_valid;
    logic             y_id;

    logic [W-1:0] xa0 [16];
    logic [W-1:0] ha0 [16];
    logic [W-1:0] xa1 [16];
    logic [W-1:0] ha1 [16];

    int checks     = 0;
    int errors     = 0;
    int cyc        = 0;
    int model_last = 1;
    int last_done  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Requesters present operands for whatever element the scheduler is asking for.
    assign x0 = xa0[elem_idx];
    assign h0 = ha0[elem_idx];
    assign x1 = xa1[elem_idx];
    assign h1 = ha1[elem_idx];

    dot_sched #(
        .N     (N),
        .W     (W),
        .ACC_W (ACC_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .x0       (x0),
        .h0       (h0),
        .x1       (x1),
        .h1       (h1),
        .grant    (grant),
        .elem_idx (elem_idx),
        .busy     (busy),
        .y        (y),
        .y_valid  (y_valid),
        .y_id     (y_id)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int dot(input int who);
        int s = 0;
        for (int k = 0; k < N; k++) begin
            if (who == 0) s += int'(xa0[k]) * int'(ha0[k]);
            else          s += int'(xa1[k]) * int'(ha1[k]);
        end
        return s;
    endfunction

    task automatic fill(input int mode, input int a0, input int b0, input int a1, input int b1);
        for (int k = 0; k < 16; k++) begin
            if (mode == 0) begin
                xa0[k] = W'(a0); ha0[k] = W'(b0); xa1[k] = W'(a1); ha1[k] = W'(b1);
            end else begin
                xa0[k] = W'($urandom_range(0, 15)); ha0[k] = W'($urandom_range(0, 15));
                xa1[k] = W'($urandom_range(0, 15)); ha1[k] = W'($urandom_range(0, 15));
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 2'b00;
        step();
        step();
        reset      = 1'b0;
        model_last = 1;
    endtask

    // Called in an idle cycle with req nonzero; runs one full job and returns in the next idle cycle.
    task automatic run_job(input int drop_at);
        int who;
        int exp_y;
        logic [1:0] exp_g;
        if (req == 2'b11) who = (model_last == 1) ? 0 : 1;
        else              who = req[1] ? 1 : 0;
        exp_y = dot(who);
        exp_g = (who == 1) ? 2'b10 : 2'b01;
        for (int k = 0; k < N; k++) begin
            step();
            chk("grant_accum", 32'(grant), 32'(exp_g));
            chk("elem_idx_seq", 32'(elem_idx), k);
            chk("busy_accum", 32'(busy), 1);
            chk("no_early_valid", 32'(y_valid), 0);
            if (k == drop_at) req[who] = 1'b0;
        end
        step();
        chk("y_valid_done", 32'(y_valid), 1);
        chk("y_result", y, exp_y);
        chk("y_id", 32'(y_id), who);
        chk("grant_done", 32'(grant), 0);
        chk("idx_done", 32'(elem_idx), 0);
        chk("busy_done", 32'(busy), 1);
        last_done  = cyc;
        model_last = who;
        req[who]   = 1'b0;
        step();
        chk("y_valid_pulse", 32'(y_valid), 0);
        chk("busy_idle", 32'(busy), 0);
        chk("y_hold", y, exp_y);
    endtask

    initial begin
        int d1;
        int seen;
        reset = 1'b1;
        req   = 2'b00;
        fill(0, 0, 0, 0, 0);
        step();
        do_reset();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_idx", 32'(elem_idx), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_y", y, 0);
        chk("rst_y_valid", 32'(y_valid), 0);
        chk("rst_y_id", 32'(y_id), 0);

        fill(0, 1, 1, 0, 0);
        req = 2'b01;
        run_job(-1);
        chk("ones_y", y, 10);

        fill(0, 0, 0, 15, 15);
        req = 2'b10;
        run_job(-1);
        chk("max_y", y, 2250);

        fill(0, 0, 2, 0, 0);
        for (int k = 0; k < 16; k++) xa0[k] = W'(k);
        req = 2'b01;
        run_job(-1);
        chk("ramp_y", y, 90);

        fill(1, 0, 0, 0, 0);
        req = 2'b01;
        run_job(3);

        do_reset();
        fill(0, 1, 1, 2, 2);
        req = 2'b11;
        run_job(-1);
        chk("contend_first", y, 10);
        d1 = last_done;
        run_job(-1);
        chk("contend_second", y, 40);
        chk("contend_spacing", last_done - d1, N + 2);
        req = 2'b11;
        run_job(-1);
        chk("alternate_id", 32'(y_id), 0);
        run_job(-1);

        fill(1, 0, 0, 0, 0);
        req = 2'b01;
        for (int t = 0; t < 20 && !(busy === 1'b1 && elem_idx === 4'd5); t++) step();
        chk("reach_idx5", 32'(elem_idx), 5);
        reset = 1'b1;
        req   = 2'b00;
        step();
        reset      = 1'b0;
        model_last = 1;
        chk("abort_grant", 32'(grant), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_y", y, 0);
        chk("abort_valid", 32'(y_valid), 0);
        chk("abort_idx", 32'(elem_idx), 0);
        seen = 0;
        for (int t = 0; t < N + 4; t++) begin
            step();
            if (y_valid !== 1'b0) seen++;
        end
        chk("abort_no_valid", seen, 0);
        req = 2'b01;
        run_job(-1);

        for (int j = 0; j < 24; j++) begin
            fill(1, 0, 0, 0, 0);
            req = req | 2'($urandom_range(0, 3));
            if (req == 2'b00) req = 2'($urandom_range(1, 3));
            run_job(int'($urandom_range(0, 2 * N)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
